cpu_bus_master: RTL

- Initiator end of the MCU system bus, inside the CPU.
- Converts single-byte read/write requests from the execution core into timed bus cycles on addr_bus, read_en, write_en and memory_select.
- The MCU-level decoder answers those cycles from ROM, internal RAM or SFRs.
- Splits the bidirectional data bus into data_in, data_out and data_oe. Returns read data or a write acknowledge to the core through a valid/ready handshake.

---
 rtl/cpu_bus_master.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: initiator end of the MCU system bus inside the CPU.
// Turns single-byte core requests into timed bus cycles (addr_bus, read_en,
// write_en, memory_select), splits the data bus into data_in/data_out/data_oe
// and answers the core with a one-cycle rsp_valid pulse.
// Optional 1-byte code prefetch buffer: define CPU_BUS_PREFETCH_EN.
module cpu_bus_master #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_space,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] addr_bus,
  output logic        memory_select,
  output logic        read_en,
  output logic        write_en,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [3:0] WS       = 4'(WAIT_STATES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        wr_q, sp_q, err_q;
  logic [7:0]  wdata_q, rdata_q;
  logic [15:0] addr_q;
  logic        accept, illegal, bus_cyc;

`ifdef CPU_BUS_PREFETCH_EN
  logic        pf_valid, pf_cycle, pf_pend;
  logic [15:0] pf_addr, pf_next;
  logic [7:0]  pf_data;
  logic        pf_hit;

  // a pending prefetch owns the next IDLE cycle, so the core is held off
  assign req_ready = reset && (state == S_IDLE) && !pf_pend;
  assign pf_hit    = !req_write && !req_space && pf_valid && (req_addr == pf_addr);
`else
  assign req_ready = reset && (state == S_IDLE);
`endif

  assign accept  = req_valid && req_ready;
  // code space is read-only: accept, skip the bus, flag the response
  assign illegal = req_write && !req_space;

  // bus-side outputs decode straight from state so strobes can never overlap
  assign bus_cyc       = (state == S_ACCESS);
  assign read_en       = bus_cyc && !wr_q;
  assign write_en      = bus_cyc && wr_q;
  assign memory_select = bus_cyc && sp_q;
  assign data_oe       = write_en;
  assign data_out      = write_en ? wdata_q : 8'h00;
  assign addr_bus      = addr_q;
  assign rsp_valid     = (state == S_RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = rsp_valid && err_q;

  // request sequencing: IDLE -> ACCESS (wait states) -> RESP -> IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      sp_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      addr_q  <= 16'h0000;
`ifdef CPU_BUS_PREFETCH_EN
      pf_valid <= 1'b0;
      pf_cycle <= 1'b0;
      pf_pend  <= 1'b0;
      pf_addr  <= 16'h0000;
      pf_next  <= 16'h0000;
      pf_data  <= 8'h00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef CPU_BUS_PREFETCH_EN
          if (pf_pend) begin
            // speculative code read of the next byte; produces no response
            pf_pend  <= 1'b0;
            pf_cycle <= 1'b1;
            pf_valid <= 1'b0;
            pf_addr  <= pf_next;
            addr_q   <= pf_next;
            wr_q     <= 1'b0;
            sp_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= WS;
            state    <= S_ACCESS;
          end else
`endif
          if (accept) begin
            wr_q    <= req_write;
            sp_q    <= req_space;
            wdata_q <= req_wdata;
            err_q   <= illegal;
            cnt     <= WS;
            if (illegal) begin
              state <= S_RESP;
`ifdef CPU_BUS_PREFETCH_EN
            end else if (pf_hit) begin
              rdata_q <= pf_data;
              state   <= S_RESP;
`endif
            end else begin
              // data space is 256 bytes: upper address byte is forced low
              addr_q <= req_space ? {8'h00, req_addr[7:0]} : req_addr;
              state  <= S_ACCESS;
            end
`ifdef CPU_BUS_PREFETCH_EN
            if (!req_write && !req_space) begin
              pf_next <= req_addr + 16'd1;
              if (!pf_hit) pf_valid <= 1'b0;
            end
`endif
          end
        end
        S_ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
`ifdef CPU_BUS_PREFETCH_EN
            if (pf_cycle) begin
              pf_data  <= data_in;
              pf_valid <= 1'b1;
              pf_cycle <= 1'b0;
              state    <= S_IDLE;
            end else
`endif
            begin
              if (!wr_q) rdata_q <= data_in;
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
`ifdef CPU_BUS_PREFETCH_EN
          // every completed core code read arms a prefetch of the next byte
          if (!wr_q && !sp_q && !err_q) pf_pend <= 1'b1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
